// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite-style memory port between the
// instruction-fetch (read-only) and data load/store requesters, one transaction at a time.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic [DATA_WIDTH-1:0]     i_rdata,
    output logic                      i_done,
    output logic                      i_err,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    input  logic [DATA_WIDTH/8-1:0]   d_wstrb,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      d_done,
    output logic                      d_err,
    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    output logic                      rready,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic                    last_grant_r, owner_r;
    logic                    grant_valid_s, grant_side_s;
    logic                    aw_ok_r, w_ok_r, aw_done_s, w_done_s, aw_ok_nxt_s, w_ok_nxt_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r, i_rdata_r, d_rdata_r;
    logic [STRB_WIDTH-1:0]   wstrb_r;
    logic                    arvalid_r, rready_r, awvalid_r, wvalid_r, bready_r;
    logic                    i_done_r, d_done_r, i_err_r, d_err_r;
    logic                    arvalid_nxt_s, rready_nxt_s, awvalid_nxt_s, wvalid_nxt_s, bready_nxt_s;
    logic                    i_done_nxt_s, d_done_nxt_s, err_nxt_s, rd_cap_s;

    // Round-robin pick: a tie goes to the side that did not win last time.
    always_comb begin
        grant_valid_s = i_req | d_req;
        if (i_req && d_req) begin
            grant_side_s = ~last_grant_r;
        end else if (d_req) begin
            grant_side_s = SIDE_D;
        end else begin
            grant_side_s = SIDE_I;
        end
        aw_done_s = aw_ok_r | (awvalid_r & awready);
        w_done_s  = w_ok_r | (wvalid_r & wready);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!grant_valid_s) begin
                    state_nxt_s = S_IDLE;
                end else if ((grant_side_s == SIDE_D) && d_we) begin
                    state_nxt_s = S_WR_REQ;
                end else begin
                    state_nxt_s = S_RD_ADDR;
                end
            end
            S_RD_ADDR: state_nxt_s = arready ? S_RD_DATA : S_RD_ADDR;
            S_RD_DATA: state_nxt_s = rvalid ? S_DONE : S_RD_DATA;
            S_WR_REQ:  state_nxt_s = (aw_done_s && w_done_s) ? S_WR_RESP : S_WR_REQ;
            S_WR_RESP: state_nxt_s = bvalid ? S_DONE : S_WR_RESP;
            S_DONE:    state_nxt_s = S_IDLE;
            default:   state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every bus/requester output is a flop.
    always_comb begin
        aw_ok_nxt_s   = (state_r == S_WR_REQ) ? aw_done_s : 1'b0;
        w_ok_nxt_s    = (state_r == S_WR_REQ) ? w_done_s : 1'b0;
        arvalid_nxt_s = (state_nxt_s == S_RD_ADDR);
        rready_nxt_s  = (state_nxt_s == S_RD_DATA);
        awvalid_nxt_s = (state_nxt_s == S_WR_REQ) && !aw_ok_nxt_s;
        wvalid_nxt_s  = (state_nxt_s == S_WR_REQ) && !w_ok_nxt_s;
        bready_nxt_s  = (state_nxt_s == S_WR_RESP);
        i_done_nxt_s  = (state_nxt_s == S_DONE) && (owner_r == SIDE_I);
        d_done_nxt_s  = (state_nxt_s == S_DONE) && (owner_r == SIDE_D);
        err_nxt_s     = (state_r == S_RD_DATA) ? (rresp != 2'b00) : (bresp != 2'b00);
        rd_cap_s      = (state_r == S_RD_DATA) && rvalid;
    end

    // State, handshake flags and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            last_grant_r <= SIDE_D;
            owner_r      <= SIDE_I;
            aw_ok_r      <= 1'b0;
            w_ok_r       <= 1'b0;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            bready_r     <= 1'b0;
            i_done_r     <= 1'b0;
            d_done_r     <= 1'b0;
            i_err_r      <= 1'b0;
            d_err_r      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            aw_ok_r   <= aw_ok_nxt_s;
            w_ok_r    <= w_ok_nxt_s;
            arvalid_r <= arvalid_nxt_s;
            rready_r  <= rready_nxt_s;
            awvalid_r <= awvalid_nxt_s;
            wvalid_r  <= wvalid_nxt_s;
            bready_r  <= bready_nxt_s;
            i_done_r  <= i_done_nxt_s;
            d_done_r  <= d_done_nxt_s;
            i_err_r   <= i_done_nxt_s & err_nxt_s;
            d_err_r   <= d_done_nxt_s & err_nxt_s;
            if ((state_r == S_IDLE) && grant_valid_s) begin
                last_grant_r <= grant_side_s;
                owner_r      <= grant_side_s;
            end else begin
                last_grant_r <= last_grant_r;
                owner_r      <= owner_r;
            end
        end
    end

    // Request latch at grant; bus address/data come only from here.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= '0;
            wdata_r <= '0;
            wstrb_r <= '0;
        end else if ((state_r == S_IDLE) && grant_valid_s) begin
            addr_r  <= (grant_side_s == SIDE_D) ? d_addr : i_addr;
            wdata_r <= d_wdata;
            wstrb_r <= (grant_side_s == SIDE_D) ? d_wstrb : '0;
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            wstrb_r <= wstrb_r;
        end
    end

    // Read data holds until the same side completes another read.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata_r <= '0;
            d_rdata_r <= '0;
        end else if (rd_cap_s && (owner_r == SIDE_I)) begin
            i_rdata_r <= rdata;
        end else if (rd_cap_s && (owner_r == SIDE_D)) begin
            d_rdata_r <= rdata;
        end else begin
            i_rdata_r <= i_rdata_r;
            d_rdata_r <= d_rdata_r;
        end
    end

    assign araddr  = addr_r;
    assign awaddr  = addr_r;
    assign wdata   = wdata_r;
    assign wstrb   = wstrb_r;
    assign arvalid = arvalid_r;
    assign rready  = rready_r;
    assign awvalid = awvalid_r;
    assign wvalid  = wvalid_r;
    assign bready  = bready_r;
    assign i_done  = i_done_r;
    assign d_done  = d_done_r;
    assign i_err   = i_err_r;
    assign d_err   = d_err_r;
    assign i_rdata = i_rdata_r;
    assign d_rdata = d_rdata_r;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a responder models the memory bus,
// a monitor pops expected bus addresses, write beats and completions as the DUT presents them.
module tb_mem_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [SW-1:0] d_wstrb = '0;
    logic [DW-1:0] i_rdata, d_rdata, rdata, wdata;
    logic i_done, i_err, d_done, d_err;
    logic [AW-1:0] araddr, awaddr;
    logic arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0] rresp, bresp;
    logic [SW-1:0] wstrb;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_vec = 0;
    int n_fail = 0;
    logic [DW:0]      exp_i_q[$];
    logic [DW:0]      exp_d_q[$];
    logic [AW-1:0]    exp_addr_q[$];
    logic [SW+DW-1:0] exp_w_q[$];
    logic [DW-1:0]    i_rdata_m = '0, d_rdata_m = '0;

    int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic [DW-1:0] rdata_cfg = '0;
    logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;
    int ar_hi = 0, aw_hi = 0, w_hi = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got unexpected event expected none", nm);
    endtask

    // Bus responder: each ready/valid rises after its configured wait count.
    initial begin
        int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (arvalid) begin arready = (ar_c >= ar_wait); ar_c++; end
            else begin arready = 1'b0; ar_c = 0; end
            if (rready) begin
                rvalid = (r_c >= r_wait); r_c++;
                rdata = rvalid ? rdata_cfg : '0;
                rresp = rvalid ? rresp_cfg : 2'b00;
            end else begin rvalid = 1'b0; r_c = 0; rdata = '0; rresp = 2'b00; end
            if (awvalid) begin awready = (aw_c >= aw_wait); aw_c++; end
            else begin awready = 1'b0; aw_c = 0; end
            if (wvalid) begin wready = (w_c >= w_wait); w_c++; end
            else begin wready = 1'b0; w_c = 0; end
            if (bready) begin
                bvalid = (b_c >= b_wait); b_c++;
                bresp = bvalid ? bresp_cfg : 2'b00;
            end else begin bvalid = 1'b0; b_c = 0; bresp = 2'b00; end
        end
    end

    // Monitor: bus ordering, valid stability, and completion scoreboard.
    initial begin
        logic p_ar = 1'b0, p_arr = 1'b0, p_aw = 1'b0, p_awr = 1'b0, p_w = 1'b0, p_wr = 1'b0, p_rst = 1'b1;
        logic [AW-1:0] p_araddr = '0, p_awaddr = '0;
        logic [DW-1:0] p_wdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (arvalid) ar_hi++;
            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            if (p_ar && !p_arr && !p_rst) begin
                chk("arvalid_held", arvalid, 1'b1);
                chk("araddr_stable", araddr, p_araddr);
            end
            if (p_aw && !p_awr && !p_rst) begin
                chk("awvalid_held", awvalid, 1'b1);
                chk("awaddr_stable", awaddr, p_awaddr);
            end
            if (p_w && !p_wr && !p_rst) begin
                chk("wvalid_held", wvalid, 1'b1);
                chk("wdata_stable", wdata, p_wdata);
            end
            if (arvalid && arready) begin
                if (exp_addr_q.size() == 0) miss("ar_unexpected");
                else chk("ar_order", araddr, exp_addr_q.pop_front());
            end
            if (awvalid && awready) begin
                if (exp_addr_q.size() == 0) miss("aw_unexpected");
                else chk("aw_order", awaddr, exp_addr_q.pop_front());
            end
            if (wvalid && wready) begin
                if (exp_w_q.size() == 0) miss("w_unexpected");
                else chk("w_beat", {wstrb, wdata}, exp_w_q.pop_front());
            end
            if (i_done) begin
                if (exp_i_q.size() == 0) miss("i_done_unexpected");
                else chk("i_resp", {i_err, i_rdata}, exp_i_q.pop_front());
            end
            if (d_done) begin
                if (exp_d_q.size() == 0) miss("d_done_unexpected");
                else chk("d_resp", {d_err, d_rdata}, exp_d_q.pop_front());
            end
            p_ar = arvalid; p_arr = arready; p_araddr = araddr;
            p_aw = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_w = wvalid; p_wr = wready; p_wdata = wdata;
            p_rst = rst;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
        cyc(2);
        rst = 1'b0;
        i_rdata_m = '0; d_rdata_m = '0;
    endtask

    task automatic do_i(input logic [AW-1:0] a);
        int t = 0;
        i_addr = a; i_req = 1'b1;
        do begin @(negedge clk); t++; end while (!i_done && t < 200);
        if (!i_done) miss("i_timeout");
        i_req = 1'b0;
    endtask

    task automatic do_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [SW-1:0] ws);
        int t = 0;
        d_we = we; d_addr = a; d_wdata = wd; d_wstrb = ws; d_req = 1'b1;
        do begin @(negedge clk); t++; end while (!d_done && t < 200);
        if (!d_done) miss("d_timeout");
        d_req = 1'b0;
    endtask

    task automatic tie(input logic [AW-1:0] ia, input logic [AW-1:0] da, input logic i_first);
        if (i_first) begin exp_addr_q.push_back(ia); exp_addr_q.push_back(da); end
        else begin exp_addr_q.push_back(da); exp_addr_q.push_back(ia); end
        i_rdata_m = rdata_cfg; d_rdata_m = rdata_cfg;
        exp_i_q.push_back({1'b0, i_rdata_m});
        exp_d_q.push_back({1'b0, d_rdata_m});
        fork
            do_i(ia);
            do_d(1'b0, da, '0, '0);
        join
        cyc(1);
    endtask

    initial begin
        do_reset();
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_awvalid_wvalid", {awvalid, wvalid}, 2'b00);
        chk("rst_rready_bready", {rready, bready}, 2'b00);
        chk("rst_done_err", {i_done, d_done, i_err, d_err}, 4'h0);
        chk("rst_rdata", {i_rdata, d_rdata}, 128'h0);

        // Single I read with cycle-exact latency.
        rdata_cfg = 64'h0000_0013_0000_0093;
        exp_addr_q.push_back(32'h8000_0000);
        exp_i_q.push_back({1'b0, 64'h0000_0013_0000_0093});
        i_addr = 32'h8000_0000; i_req = 1'b1;
        cyc(1); chk("lat_c1_arvalid", {arvalid, i_done}, 2'b10);
        cyc(1); chk("lat_c2_rready", rready, 1'b1);
        cyc(1); chk("lat_c3_done", {i_done, d_done, i_err}, 3'b100);
        chk("lat_c3_rdata", i_rdata, 64'h0000_0013_0000_0093);
        i_req = 1'b0;
        cyc(1); chk("i_done_single", i_done, 1'b0);
        cyc(2);

        // Round-robin: tie after reset goes to I; later ties alternate by last grant.
        do_reset();
        rdata_cfg = 64'h1111_2222_3333_4444;
        tie(32'h8000_0100, 32'h9000_0000, 1'b1);
        exp_addr_q.push_back(32'h8000_0200);
        i_rdata_m = rdata_cfg; exp_i_q.push_back({1'b0, i_rdata_m});
        do_i(32'h8000_0200);
        cyc(1);
        rdata_cfg = 64'h5555_6666_7777_8888;
        tie(32'h8000_0300, 32'h9000_0008, 1'b0);

        // Write with aw accepted at once, w after 3 wait cycles, b after 2.
        aw_wait = 0; w_wait = 3; b_wait = 2;
        ar_hi = 0; aw_hi = 0; w_hi = 0;
        exp_addr_q.push_back(32'ha000_03f8);
        exp_w_q.push_back({8'h01, 64'h41});
        exp_d_q.push_back({1'b0, d_rdata_m});
        do_d(1'b1, 32'ha000_03f8, 64'h41, 8'h01);
        chk("aw_cycles", aw_hi, 1);
        chk("w_cycles", w_hi, 4);
        cyc(1);
        chk("d_done_single", d_done, 1'b0);
        w_wait = 0; b_wait = 0;

        // Last grant is now D, so the next tie goes to I.
        rdata_cfg = 64'h0123_4567_89ab_cdef;
        tie(32'h8000_0400, 32'h9000_0010, 1'b1);

        // Address backpressure with a changing requester address, then an error response.
        ar_wait = 5; rresp_cfg = 2'b10; rdata_cfg = 64'hdead_beef_0000_0001;
        ar_hi = 0;
        exp_addr_q.push_back(32'h9000_0040);
        d_rdata_m = rdata_cfg; exp_d_q.push_back({1'b1, d_rdata_m});
        fork
            do_d(1'b0, 32'h9000_0040, '0, '0);
            begin
                cyc(1);
                repeat (6) begin d_addr = d_addr + 32'h8; cyc(1); end
            end
        join
        chk("ar_backpressure_cycles", ar_hi, 6);
        ar_wait = 0; rresp_cfg = 2'b00;
        cyc(1);

        // Reset while waiting in RD_DATA abandons the read silently.
        r_wait = 1000;
        begin
            int t = 0;
            exp_addr_q.push_back(32'h8000_0500);
            i_addr = 32'h8000_0500; i_req = 1'b1;
            do begin cyc(1); t++; end while (!rready && t < 20);
            chk("reached_rd_data", rready, 1'b1);
        end
        rst = 1'b1; i_req = 1'b0;
        cyc(1);
        chk("midrst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'h0);
        chk("midrst_done", {i_done, d_done, i_err, d_err}, 4'h0);
        chk("midrst_rdata", {i_rdata, d_rdata}, 128'h0);
        rst = 1'b0; r_wait = 0;
        i_rdata_m = '0; d_rdata_m = '0;
        cyc(1);
        rdata_cfg = 64'hfeed_0000_cafe_0000;
        tie(32'h8000_0600, 32'h9000_0080, 1'b1);
        cyc(3);

        chk("queues_drained", exp_i_q.size() + exp_d_q.size() + exp_addr_q.size() + exp_w_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
